symme_pwm_timer: RTL

Parametrised successor to the symmetric timer. It provides a width-generic up, down or symmetric (up/down) counter with programmable terminal value, a compare-based PWM output, period/top event pulses and one-shot mode. It sits in the timer subsystem and drives PWM pins and interrupt/event logic; all outputs are registered.

---
 rtl/symme_timer_pkg.sv | 17 +
 rtl/symme_timer_shadow.sv | 30 +++
 rtl/symme_pwm_timer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/symme_timer_pkg.sv
// Shared types for the symmetric PWM timer: counting modes and control states.
package symme_timer_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_SYM  = 2'd2,
    MODE_RSV  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/symme_timer_shadow.sv
// Shadow capture registers for terminal and compare values; a load strobe
// copies the live configuration so mid-period writes wait for the next period.
module symme_timer_shadow #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] max_i,
  input  logic [CNT_W-1:0] cmp_i,
  output logic [CNT_W-1:0] max_o,
  output logic [CNT_W-1:0] cmp_o
);

  logic [CNT_W-1:0] max_q, cmp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      cmp_q <= '0;
    end else if (load_i) begin
      max_q <= max_i;
      cmp_q <= cmp_i;
    end
  end

  assign max_o = max_q;
  assign cmp_o = cmp_q;

endmodule

// File: rtl/symme_pwm_timer.sv
// Width-generic up/down/symmetric PWM timer with period/top events and one-shot.
// Define SYMME_TIMER_SHADOW_EN to buffer cfg_max/cfg_cmp until each period boundary.
module symme_pwm_timer
  import symme_timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_oneshot,
  input  logic [CNT_W-1:0] cfg_max,
  input  logic [CNT_W-1:0] cfg_cmp,
  output logic [CNT_W-1:0] cnt,
  output logic             dir,
  output logic             pwm,
  output logic             prd_evt,
  output logic             top_evt,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             oneshot_q, oneshot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             pwm_q, pwm_d;
  logic             prd_q, prd_d;
  logic             top_q, top_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] max_eff;
  logic [CNT_W-1:0] cmp_pwm;

`ifdef SYMME_TIMER_SHADOW_EN
  logic             shadow_load;
  logic [CNT_W-1:0] max_sh, cmp_sh;

  assign shadow_load = ((state_q == ST_IDLE) && en) || ((state_q == ST_RUN) && prd_q);

  symme_timer_shadow #(.CNT_W(CNT_W)) u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (shadow_load),
    .max_i  (cfg_max),
    .cmp_i  (cfg_cmp),
    .max_o  (max_sh),
    .cmp_o  (cmp_sh)
  );

  assign max_eff = max_sh;
  // pwm is registered with cnt, so it uses the compare value valid in that next cycle.
  assign cmp_pwm = shadow_load ? cfg_cmp : cmp_sh;
`else
  assign max_eff = cfg_max;
  assign cmp_pwm = cfg_cmp;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d   = state_q;
    mode_d    = mode_q;
    oneshot_d = oneshot_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    pwm_d     = 1'b0;
    prd_d     = 1'b0;
    top_d     = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        dir_d = 1'b1;
        if (en) begin
          state_d   = ST_RUN;
          mode_d    = mode_e'(cfg_mode);
          oneshot_d = cfg_oneshot;
          cnt_d     = (mode_e'(cfg_mode) == MODE_DOWN) ? cfg_max : '0;
          dir_d     = (mode_e'(cfg_mode) != MODE_DOWN);
          pwm_d     = (cnt_d < cmp_pwm);
        end
      end

      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          dir_d   = 1'b1;
        end else if (oneshot_q && prd_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          case (mode_q)
            MODE_DOWN: begin
              dir_d = 1'b0;
              if (cnt_q > max_eff) begin
                cnt_d = max_eff;
              end else begin
                cnt_d = (cnt_q == '0) ? max_eff : cnt_q - CNT_W'(1);
                prd_d = (cnt_d == '0);
              end
            end
            MODE_SYM: begin
              if (max_eff == '0) begin
                cnt_d = '0;
                dir_d = 1'b1;
                prd_d = 1'b1;
                top_d = 1'b1;
              end else if (dir_q) begin
                if (cnt_q >= max_eff - CNT_W'(1)) begin
                  cnt_d = max_eff;
                  dir_d = 1'b0;
                  top_d = 1'b1;
                end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                end
              end else if (cnt_q <= CNT_W'(1)) begin
                cnt_d = '0;
                dir_d = 1'b1;
                prd_d = 1'b1;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
            default: begin
              dir_d = 1'b1;
              if (cnt_q >= max_eff) begin
                cnt_d = '0;
                // A live drop of max below cnt still ends the period with an event.
                prd_d = (cnt_q > max_eff) || (max_eff == '0);
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
                prd_d = (cnt_d == max_eff);
              end
            end
          endcase
          if (oneshot_q && prd_d) begin
            cnt_d = (mode_q == MODE_DOWN || mode_q == MODE_SYM) ? '0 : max_eff;
          end
          pwm_d = (cnt_d < cmp_pwm);
        end
      end

      ST_DONE: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          dir_d   = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        dir_d   = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_UP;
      oneshot_q <= 1'b0;
      cnt_q     <= '0;
      dir_q     <= 1'b1;
      pwm_q     <= 1'b0;
      prd_q     <= 1'b0;
      top_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      oneshot_q <= oneshot_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      pwm_q     <= pwm_d;
      prd_q     <= prd_d;
      top_q     <= top_d;
      done_q    <= done_d;
    end
  end

  assign cnt     = cnt_q;
  assign dir     = dir_q;
  assign pwm     = pwm_q;
  assign prd_evt = prd_q;
  assign top_evt = top_q;
  assign done    = done_q;

endmodule
